// File: rtl/l2_pkg.sv
// l2_pkg: shared state encoding and index helpers for the set-associative L2 cache
package l2_pkg;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WB, REFILL, FILL, RESP, FL_SCAN, FL_WB, FL_DONE
    } state_t;

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r |= oh[i] ? 3'(i) : 3'd0;
        return r;
    endfunction

endpackage

// File: rtl/l2_way_array.sv
// l2_way_array: one way's tag/valid/dirty/data storage, synchronous write, combinational read
module l2_way_array #(
    parameter int TAG_W  = 18,
    parameter int IDX_W  = 8,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [IDX_W-1:0]  idx,
    input  logic              wr,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic              clr,
    input  logic              inv,
    output logic [TAG_W-1:0]  tag,
    output logic              valid,
    output logic              dirty,
    output logic [LINE_W-1:0] line
);

    localparam int SETS = 2 ** IDX_W;

    logic [SETS-1:0]   v;
    logic [SETS-1:0]   d;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];

    // Valid/dirty flags; invalidate beats install beats dirty-clear
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            v <= '0;
            d <= '0;
        end else if (inv) begin
            v[idx] <= 1'b0;
            d[idx] <= 1'b0;
        end else if (wr) begin
            v[idx] <= 1'b1;
            d[idx] <= wr_dirty;
        end else if (clr)
            d[idx] <= 1'b0;

    // Tag and line storage, deliberately left unreset
    always_ff @(posedge clk)
        if (wr) begin
            tags[idx]  <= wr_tag;
            lines[idx] <= wr_line;
        end

    assign tag   = tags[idx];
    assign line  = lines[idx];
    assign valid = v[idx];
    assign dirty = d[idx];

endmodule

// File: rtl/l2_cache_assoc.sv
// l2_cache_assoc: N-way write-back L2 with round-robin replacement and whole-cache flush
module l2_cache_assoc #(
    parameter int TAG_W  = 18,
    parameter int IDX_W  = 8,
    parameter int LINE_W = 512,
    parameter int WAYS   = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [TAG_W-1:0]  tag_L1_L2,
    input  logic [IDX_W-1:0]  index_L1_L2,
    input  logic              read_L1_L2,
    input  logic              write_L1_L2,
    input  logic [LINE_W-1:0] write_data,
    input  logic              flush,
    output logic              ready_L2_L1,
    output logic [LINE_W-1:0] read_data_L2_L1,
    output logic              flush_done,
    output logic              read_L2_MEM,
    output logic [TAG_W-1:0]  tag_L2_MEM,
    output logic [IDX_W-1:0]  index_L2_MEM,
    output logic              write_L2_MEM,
    output logic [TAG_W-1:0]  write_tag_L2_MEM,
    output logic [LINE_W-1:0] write_data_L2_MEM,
    input  logic [LINE_W-1:0] read_data_MEM_L2,
    input  logic              ready_MEM_L2
);

    import l2_pkg::*;

    localparam int SETS  = 2 ** IDX_W;
    localparam int WAY_W = way_bits(WAYS);

    state_t            state;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [LINE_W-1:0] req_line;
    logic [LINE_W-1:0] fill_line;
    logic              req_wr;
    logic [WAY_W-1:0]  rr [SETS];
    logic [IDX_W-1:0]  fl_set;
    logic [WAY_W-1:0]  fl_way;

    logic [WAYS-1:0]   w_valid;
    logic [WAYS-1:0]   w_dirty;
    logic [TAG_W-1:0]  w_tag  [WAYS];
    logic [LINE_W-1:0] w_line [WAYS];

    logic              flushing;
    logic [IDX_W-1:0]  arr_idx;
    logic [WAY_W-1:0]  victim;
    logic [WAY_W-1:0]  sel;
    logic [WAY_W-1:0]  rr_next;
    logic [WAY_W-1:0]  hit_idx;
    logic [WAYS-1:0]   hit;
    logic [WAYS-1:0]   wr_en;
    logic [WAYS-1:0]   clr_en;
    logic [WAYS-1:0]   inv_en;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] wr_line;
    logic              sel_dirty;
    logic              fl_way_last;
    logic              fl_last;
    logic              fl_adv;

    assign victim = rr[req_idx];

    // Tag compare, AND-OR hit mux and per-way write strobes for the current state
    always_comb begin
        flushing    = (state == FL_SCAN) || (state == FL_WB);
        arr_idx     = flushing ? fl_set : req_idx;
        sel         = flushing ? fl_way : victim;
        hit         = '0;
        hit_line    = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit[w]   = w_valid[w] && (w_tag[w] == req_tag);
            hit_line = hit_line | ({LINE_W{hit[w]}} & w_line[w]);
        end
        hit_idx     = WAY_W'(onehot_to_idx(8'(hit)));
        sel_dirty   = w_valid[sel] && w_dirty[sel];
        rr_next     = (WAYS == 1) ? '0 : victim + WAY_W'(1);
        fl_way_last = fl_way == WAY_W'(WAYS - 1);
        fl_last     = fl_way_last && (&fl_set);
        fl_adv      = ((state == FL_SCAN) && !sel_dirty) || ((state == FL_WB) && ready_MEM_L2);
        wr_line     = req_wr ? req_line : fill_line;
        wr_en       = ((state == LOOKUP) && req_wr && (|hit)) ? WAYS'(1) << hit_idx :
                      (state == FILL) ? WAYS'(1) << victim : '0;
        clr_en      = ((state == WB) && ready_MEM_L2) ? WAYS'(1) << victim : '0;
        inv_en      = fl_adv ? WAYS'(1) << fl_way : '0;
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        l2_way_array #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) u_way (
            .clk      (clk),
            .nrst     (nrst),
            .idx      (arr_idx),
            .wr       (wr_en[g]),
            .wr_dirty (req_wr),
            .wr_tag   (req_tag),
            .wr_line  (wr_line),
            .clr      (clr_en[g]),
            .inv      (inv_en[g]),
            .tag      (w_tag[g]),
            .valid    (w_valid[g]),
            .dirty    (w_dirty[g]),
            .line     (w_line[g])
        );
    end

    // Controller FSM with registered outputs, round-robin pointers and flush walker
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state             <= IDLE;
            req_tag           <= '0;
            req_idx           <= '0;
            req_line          <= '0;
            req_wr            <= 1'b0;
            fill_line         <= '0;
            fl_set            <= '0;
            fl_way            <= '0;
            ready_L2_L1       <= 1'b0;
            read_data_L2_L1   <= '0;
            flush_done        <= 1'b0;
            read_L2_MEM       <= 1'b0;
            tag_L2_MEM        <= '0;
            index_L2_MEM      <= '0;
            write_L2_MEM      <= 1'b0;
            write_tag_L2_MEM  <= '0;
            write_data_L2_MEM <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            ready_L2_L1 <= 1'b0;
            flush_done  <= 1'b0;
            case (state)
                IDLE:
                    if (flush) begin
                        fl_set <= '0;
                        fl_way <= '0;
                        state  <= FL_SCAN;
                    end else if (read_L1_L2 || write_L1_L2) begin
                        req_tag  <= tag_L1_L2;
                        req_idx  <= index_L1_L2;
                        req_line <= write_data;
                        req_wr   <= write_L1_L2;
                        state    <= LOOKUP;
                    end
                LOOKUP:
                    if (|hit) begin
                        ready_L2_L1     <= 1'b1;
                        read_data_L2_L1 <= req_wr ? '0 : hit_line;
                        state           <= RESP;
                    end else if (sel_dirty) begin
                        write_L2_MEM      <= 1'b1;
                        write_tag_L2_MEM  <= w_tag[sel];
                        write_data_L2_MEM <= w_line[sel];
                        index_L2_MEM      <= arr_idx;
                        state             <= WB;
                    end else if (req_wr)
                        state <= FILL;
                    else begin
                        read_L2_MEM  <= 1'b1;
                        tag_L2_MEM   <= req_tag;
                        index_L2_MEM <= req_idx;
                        state        <= REFILL;
                    end
                WB:
                    if (ready_MEM_L2) begin
                        write_L2_MEM <= 1'b0;
                        read_L2_MEM  <= !req_wr;
                        tag_L2_MEM   <= req_tag;
                        index_L2_MEM <= req_idx;
                        state        <= req_wr ? FILL : REFILL;
                    end
                REFILL:
                    if (ready_MEM_L2) begin
                        read_L2_MEM <= 1'b0;
                        fill_line   <= read_data_MEM_L2;
                        state       <= FILL;
                    end
                FILL: begin
                    rr[req_idx]     <= rr_next;
                    ready_L2_L1     <= 1'b1;
                    read_data_L2_L1 <= req_wr ? '0 : fill_line;
                    state           <= RESP;
                end
                RESP: begin
                    read_data_L2_L1 <= '0;
                    state           <= IDLE;
                end
                FL_SCAN:
                    if (sel_dirty) begin
                        write_L2_MEM      <= 1'b1;
                        write_tag_L2_MEM  <= w_tag[sel];
                        write_data_L2_MEM <= w_line[sel];
                        index_L2_MEM      <= arr_idx;
                        state             <= FL_WB;
                    end
                FL_WB:
                    if (ready_MEM_L2) write_L2_MEM <= 1'b0;
                FL_DONE: begin
                    for (int s = 0; s < SETS; s++) rr[s] <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (fl_adv) begin
                fl_way     <= fl_way_last ? '0 : fl_way + WAY_W'(1);
                fl_set     <= fl_set + IDX_W'(fl_way_last);
                flush_done <= fl_last;
                state      <= fl_last ? FL_DONE : FL_SCAN;
            end
        end

endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb_l2_cache_assoc: directed vectors with a 3-cycle memory responder and a logging monitor
`timescale 1ns/1ps
module tb_l2_cache_assoc;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [17:0]  tag_L1_L2 = '0;
    logic [7:0]   index_L1_L2 = '0;
    logic         read_L1_L2 = 1'b0;
    logic         write_L1_L2 = 1'b0;
    logic [511:0] write_data = '0;
    logic         flush = 1'b0;
    logic         ready_L2_L1;
    logic [511:0] read_data_L2_L1;
    logic         flush_done;
    logic         read_L2_MEM;
    logic [17:0]  tag_L2_MEM;
    logic [7:0]   index_L2_MEM;
    logic         write_L2_MEM;
    logic [17:0]  write_tag_L2_MEM;
    logic [511:0] write_data_L2_MEM;
    logic [511:0] read_data_MEM_L2 = '0;
    logic         ready_MEM_L2 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int mcnt = 0;
    int n_rd = 0;
    int n_wr = 0;
    int fd_cnt = 0;
    int overlap = 0;
    logic [511:0] mem_line = '0;
    logic [17:0]  rd_tag;
    logic [7:0]   rd_idx;
    logic [17:0]  wb_tag [$];
    logic [7:0]   wb_idx [$];
    logic [511:0] wb_data [$];
    int           ev [$];

    l2_cache_assoc #(.TAG_W(18), .IDX_W(8), .LINE_W(512), .WAYS(4)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .tag_L1_L2         (tag_L1_L2),
        .index_L1_L2       (index_L1_L2),
        .read_L1_L2        (read_L1_L2),
        .write_L1_L2       (write_L1_L2),
        .write_data        (write_data),
        .flush             (flush),
        .ready_L2_L1       (ready_L2_L1),
        .read_data_L2_L1   (read_data_L2_L1),
        .flush_done        (flush_done),
        .read_L2_MEM       (read_L2_MEM),
        .tag_L2_MEM        (tag_L2_MEM),
        .index_L2_MEM      (index_L2_MEM),
        .write_L2_MEM      (write_L2_MEM),
        .write_tag_L2_MEM  (write_tag_L2_MEM),
        .write_data_L2_MEM (write_data_L2_MEM),
        .read_data_MEM_L2  (read_data_MEM_L2),
        .ready_MEM_L2      (ready_MEM_L2)
    );

    always #5 clk = ~clk;

    // Memory answers every request on the third edge it sees it; logs handshakes
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mcnt = 0;
            ready_MEM_L2 <= 1'b0;
        end else begin
            ready_MEM_L2 <= 1'b0;
            if (read_L2_MEM && write_L2_MEM) overlap++;
            if (flush_done) fd_cnt++;
            if ((read_L2_MEM || write_L2_MEM) && !ready_MEM_L2) begin
                mcnt++;
                if (mcnt == 1 && read_L2_MEM) begin
                    n_rd++;
                    rd_tag = tag_L2_MEM;
                    rd_idx = index_L2_MEM;
                    ev.push_back(2);
                end
                if (mcnt == 3) begin
                    mcnt = 0;
                    ready_MEM_L2     <= 1'b1;
                    read_data_MEM_L2 <= mem_line;
                    if (write_L2_MEM) begin
                        n_wr++;
                        wb_tag.push_back(write_tag_L2_MEM);
                        wb_idx.push_back(index_L2_MEM);
                        wb_data.push_back(write_data_L2_MEM);
                        ev.push_back(1);
                    end
                end
            end
        end
    end

    function automatic logic [511:0] mk(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wb_tag.delete();
        wb_idx.delete();
        wb_data.delete();
        ev.delete();
    endtask

    // lat = number of the cycle after the accept edge T in which ready is seen (hit = 2)
    task automatic acc(input string name, input logic wr, input logic [17:0] t, input logic [7:0] i,
                       input logic [511:0] d, input int exp_lat, input logic [511:0] exp_rd);
        int lat;
        repeat (2) @(negedge clk);
        tag_L1_L2   = t;
        index_L1_L2 = i;
        write_data  = d;
        write_L1_L2 = wr;
        read_L1_L2  = !wr;
        @(posedge clk);
        lat = 1;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready_L2_L1 && lat < 300);
        check({name, " latency"}, 512'(lat), 512'(exp_lat));
        check({name, " data"}, read_data_L2_L1, exp_rd);
        read_L1_L2  = 1'b0;
        write_L1_L2 = 1'b0;
    endtask

    task automatic do_flush(input string name);
        int k;
        int fd0;
        fd0 = fd_cnt;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        k = 0;
        while (!flush_done && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, " flush_done"}, 512'(flush_done), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        check({name, " flush_done one cycle"}, 512'(fd_cnt - fd0), 512'(1));
    endtask

    initial begin
        int r0;
        int w0;
        int k;
        repeat (3) @(negedge clk);
        check("reset ready", 512'(ready_L2_L1), 512'(0));
        check("reset flush_done", 512'(flush_done), 512'(0));
        check("reset mem read", 512'(read_L2_MEM), 512'(0));
        check("reset mem write", 512'(write_L2_MEM), 512'(0));
        check("reset read data", read_data_L2_L1, '0);
        nrst = 1'b1;

        // 1: cold read miss then hit
        mem_line = mk(8'hA5);
        acc("t1 cold read", 1'b0, 18'h00001, 8'h05, '0, 7, mk(8'hA5));
        check("t1 mem read count", 512'(n_rd), 512'(1));
        check("t1 refill tag", 512'(rd_tag), 512'(18'h00001));
        check("t1 refill idx", 512'(rd_idx), 512'(8'h05));
        acc("t1 hit", 1'b0, 18'h00001, 8'h05, '0, 2, mk(8'hA5));
        check("t1 hit no mem", 512'(n_rd), 512'(1));

        // 2: write allocate without fetch, then hit on written data
        acc("t2 write", 1'b1, 18'h00002, 8'h05, mk(8'hB2), 3, '0);
        acc("t2 read back", 1'b0, 18'h00002, 8'h05, '0, 2, mk(8'hB2));
        check("t2 no mem", 512'(n_rd + n_wr), 512'(1));

        // 3: fill the set, clean eviction of way 0, dirty eviction of way 1
        acc("t3 w3", 1'b1, 18'h00003, 8'h05, mk(8'hC3), 3, '0);
        acc("t3 w4", 1'b1, 18'h00004, 8'h05, mk(8'hC4), 3, '0);
        acc("t3 w5 clean evict", 1'b1, 18'h00005, 8'h05, mk(8'hC5), 3, '0);
        check("t3 clean evict no wb", 512'(n_wr), 512'(0));
        clear_logs();
        acc("t3 w6 dirty evict", 1'b1, 18'h00006, 8'h05, mk(8'hC6), 7, '0);
        check("t3 wb count", 512'(n_wr), 512'(1));
        check("t3 wb tag", 512'(wb_tag[0]), 512'(18'h00002));
        check("t3 wb idx", 512'(wb_idx[0]), 512'(8'h05));
        check("t3 wb data", wb_data[0], mk(8'hB2));

        // 4: read miss with dirty victim (way 2, tag 3) writes back before refill
        clear_logs();
        mem_line = mk(8'hD1);
        acc("t4 read miss", 1'b0, 18'h00001, 8'h05, '0, 11, mk(8'hD1));
        check("t4 event count", 512'(ev.size()), 512'(2));
        check("t4 wb first", 512'(ev[0]), 512'(1));
        check("t4 read second", 512'(ev[1]), 512'(2));
        check("t4 wb tag", 512'(wb_tag[0]), 512'(18'h00003));
        check("t4 wb data", wb_data[0], mk(8'hC3));
        check("t4 refill tag", 512'(rd_tag), 512'(18'h00001));
        acc("t4 way0 hit", 1'b0, 18'h00005, 8'h05, '0, 2, mk(8'hC5));

        // 5: flush away set 5, then flush three dirty lines in sets 0, 7, 255
        w0 = n_wr;
        do_flush("t5 pre");
        check("t5 pre wb count", 512'(n_wr - w0), 512'(3));
        acc("t5 w set0", 1'b1, 18'h00011, 8'h00, mk(8'h11), 3, '0);
        acc("t5 w set7", 1'b1, 18'h00022, 8'h07, mk(8'h22), 3, '0);
        acc("t5 w set255", 1'b1, 18'h00033, 8'hFF, mk(8'h33), 3, '0);
        mem_line = mk(8'h44);
        acc("t5 clean set9", 1'b0, 18'h00044, 8'h09, '0, 7, mk(8'h44));
        clear_logs();
        w0 = n_wr;
        do_flush("t5");
        check("t5 wb count", 512'(n_wr - w0), 512'(3));
        check("t5 wb0 idx", 512'(wb_idx[0]), 512'(8'h00));
        check("t5 wb1 idx", 512'(wb_idx[1]), 512'(8'h07));
        check("t5 wb2 idx", 512'(wb_idx[2]), 512'(8'hFF));
        check("t5 wb1 tag", 512'(wb_tag[1]), 512'(18'h00022));
        check("t5 wb2 data", wb_data[2], mk(8'h33));
        r0 = n_rd;
        mem_line = mk(8'h55);
        acc("t5 set0 miss", 1'b0, 18'h00011, 8'h00, '0, 7, mk(8'h55));
        acc("t5 set9 miss", 1'b0, 18'h00044, 8'h09, '0, 7, mk(8'h55));
        check("t5 post-flush refills", 512'(n_rd - r0), 512'(2));

        // 6: reset during refill drops the memory request and empties the cache
        mem_line = mk(8'h60);
        acc("t6 install", 1'b0, 18'h00040, 8'h20, '0, 7, mk(8'h60));
        repeat (2) @(negedge clk);
        tag_L1_L2   = 18'h00041;
        index_L1_L2 = 8'h20;
        read_L1_L2  = 1'b1;
        k = 0;
        while (!read_L2_MEM && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t6 refill active", 512'(read_L2_MEM), 512'(1));
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check("t6 read drops in reset", 512'(read_L2_MEM), 512'(0));
        check("t6 ready low in reset", 512'(ready_L2_L1), 512'(0));
        read_L1_L2 = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        r0 = n_rd;
        mem_line = mk(8'h61);
        acc("t6 miss after reset", 1'b0, 18'h00040, 8'h20, '0, 7, mk(8'h61));
        check("t6 refill issued", 512'(n_rd - r0), 512'(1));
        check("mem read/write overlap", 512'(overlap), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
